// File: rtl/core_pkg.sv
// Purpose : shared core types and constants for the fetch front end.
// Latency : n/a (declarations only).
// Backpr.  : n/a.
package core_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0033;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Purpose : IF/ID pipeline register with valid/ready hold and flush.
// Latency : one cycle from load_i to valid_o.
// Backpr.  : contents held while valid_o && !ready_i; flush_i beats load and ready.
module if_id_reg
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     inst_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     inst_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;

  // Next contents: flush drops the entry, load captures a new one, otherwise
  // an accepted entry retires and an unaccepted one holds.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      inst_d  = inst_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Register state; reset leaves a NOP in place so decode never sees X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= INST_NOP;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Purpose : instruction fetch; owns the PC, addresses imem, fills IF/ID (optional FETCH_PERF_CNT_EN counters).
// Latency : one cycle from PC to id_valid; one bubble cycle after reset release.
// Backpr.  : PC and IF/ID hold while id_valid && !id_ready; redirect flushes regardless.
module if_fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_inst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               halt,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [XLEN-1:0]    id_pc,
  output logic [31:0]        id_inst,
  output logic               fetch_misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            advance;

  // Word index straight from the PC; the memory answers in the same cycle.
  assign imem_addr = pc_q[IMEM_AW+1:2];

  // Next state / PC: redirect beats halt, halt beats a normal fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    advance    = 1'b0;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      state_d = S_RUN;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (halt) begin
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN: begin
          if (!id_valid || id_ready) begin
            advance = 1'b1;
            pc_d    = pc_q + PC_STEP;
          end
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_BOOT;
      endcase
    end
  end

  // State, PC and sticky misalign flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign fetch_misalign = misalign_q;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (advance),
    .flush_i (redirect_valid),
    .pc_i    (pc_q),
    .inst_i  (imem_inst),
    .ready_i (id_ready),
    .valid_o (id_valid),
    .pc_o    (id_pc),
    .inst_o  (id_inst)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] bubbles_q, bubbles_d;

  // Count delivered instructions and run-state cycles that carry no useful work.
  always_comb begin
    fetched_d = fetched_q;
    bubbles_d = bubbles_q;
    if (id_valid && id_ready) begin
      fetched_d = fetched_q + 32'd1;
    end
    if ((state_q == S_RUN) && (!id_valid || redirect_valid)) begin
      bubbles_d = bubbles_q + 32'd1;
    end
  end

  // Counter registers, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Purpose : self-checking bench for if_fetch_stage against a cycle reference model.
// Latency : n/a.
// Backpr.  : exercises id_ready backpressure, redirect, halt and reset.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        fetch_misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .fetch_misalign (fetch_misalign)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  // Instruction memory: combinational read.
  logic [31:0] mem [16];
  assign imem_inst = mem[imem_addr];

  // Reference model: architectural view of the fetch stage.
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode;
  logic [31:0] m_pc, m_ipc, m_inst, m_fetched, m_bubbles;
  bit          m_valid, m_mis;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = 32'h0; m_valid = 0; m_ipc = 32'h0;
    m_inst = 32'h0000_0033; m_mis = 0; m_fetched = 0; m_bubbles = 0;
  endtask

  task automatic compare_all();
    check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
    if (m_valid) begin
      check("id_pc", id_pc, m_ipc);
      check("id_inst", id_inst, m_inst);
    end
    check("imem_addr", {28'b0, imem_addr}, {28'b0, m_pc[5:2]});
    check("misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
  endtask

  // One clock: drive inputs at negedge, advance the model, compare at next negedge.
  task automatic tick(input bit r, input logic [31:0] rpc, input bit h, input bit rdy);
    bit xfer;
    redirect_valid = r; redirect_pc = rpc; halt = h; id_ready = rdy;
    xfer = m_valid && rdy;
    if (xfer) m_fetched++;
    if (m_mode == M_RUN && (!m_valid || r)) m_bubbles++;
    if (r) begin
      m_pc = {rpc[31:2], 2'b00}; m_valid = 0; m_mode = M_RUN;
      if (rpc[1:0] != 2'b00) m_mis = 1;
    end else if (h) begin
      m_mode = M_HALT;
      if (xfer) m_valid = 0;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (!m_valid || rdy) begin
        m_inst = mem[m_pc[5:2]]; m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
      end
    end else begin
      if (xfer) m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Assert reset from a negedge, check the asynchronous response, release at the next negedge.
  task automatic do_reset();
    redirect_valid = 0; redirect_pc = 0; halt = 0; id_ready = 1;
    rst_n = 1'b0;
    #1;
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_imem_addr", {28'b0, imem_addr}, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_inst", id_inst, 32'h0000_0033);
    check("rst_misalign", {31'b0, fetch_misalign}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_bubbles", perf_bubbles, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Boot sequence shared by the first run and the mid-stream reset.
  task automatic boot_check(input string tag);
    tick(0, 0, 0, 1);
    check({tag, "_boot_valid"}, {31'b0, id_valid}, 32'h0);
    tick(0, 0, 0, 1);
    check({tag, "_pc0"}, id_pc, 32'h0);
    check({tag, "_inst0"}, id_inst, 32'h4017_D793);
    tick(0, 0, 0, 1);
    check({tag, "_pc4"}, id_pc, 32'h4);
    check({tag, "_inst1"}, id_inst, 32'h0017_D793);
    tick(0, 0, 0, 1);
    check({tag, "_pc8"}, id_pc, 32'h8);
    check({tag, "_inst2"}, id_inst, 32'h0017_9793);
  endtask

  initial begin
    logic [31:0] rpc;
    mem[0] = 32'h4017_D793; mem[1] = 32'h0017_D793; mem[2] = 32'h0017_9793;
    mem[3] = 32'h0020_8093; mem[4] = 32'h0031_0113; mem[5] = 32'h0041_8193;
    mem[6] = 32'h0052_0213; mem[7] = 32'h0062_8293; mem[8] = 32'h0073_0313;
    mem[9] = 32'h0000_0073;
    for (int i = 10; i < 16; i++) mem[i] = 32'hA5A5_0000 + i;
    rst_n = 1'b0; redirect_valid = 0; redirect_pc = 0; halt = 0; id_ready = 1;
    model_reset();
    @(negedge clk);
    do_reset();

    boot_check("boot");

    // Rewind so the held entry is id_pc = 4, then stall three cycles.
    tick(1, 32'h4, 0, 0);
    tick(0, 0, 0, 0);
    check("stall_pc_start", id_pc, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0);
      check("stall_pc", id_pc, 32'h4);
      check("stall_inst", id_inst, 32'h0017_D793);
      check("stall_addr", {28'b0, imem_addr}, 32'h2);
    end
    tick(0, 0, 0, 1);
    check("stall_release_pc", id_pc, 32'h8);

    // Redirect while a valid entry is stalled: it must be dropped.
    tick(1, 32'h14, 0, 0);
    check("redir_flush", {31'b0, id_valid}, 32'h0);
    tick(0, 0, 0, 1);
    check("redir_pc", id_pc, 32'h14);
    check("redir_inst", id_inst, 32'h0041_8193);

    // Halt with id_pc = 8 held and pc = 0xC.
    tick(1, 32'h8, 0, 1);
    tick(0, 0, 0, 1);
    tick(1'b0, 0, 1'b1, 1'b0);
    check("halt_hold_valid", {31'b0, id_valid}, 32'h1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    check("halt_drop_valid", {31'b0, id_valid}, 32'h0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    check("halt_no_fetch", {28'b0, imem_addr}, 32'h3);
    tick(1, 32'h0, 0, 1);
    tick(0, 0, 0, 1);
    check("halt_resume_pc", id_pc, 32'h0);

    // Misaligned redirect target.
    tick(1, 32'h6, 0, 1);
    check("mis_addr", {28'b0, imem_addr}, 32'h1);
    check("mis_flag", {31'b0, fetch_misalign}, 32'h1);
    tick(0, 0, 0, 1);
    check("mis_pc", id_pc, 32'h4);

    // PC wrap at the top of the address space.
    tick(1, 32'hFFFF_FFFC, 0, 1);
    tick(0, 0, 0, 1);
    check("wrap_top_pc", id_pc, 32'hFFFF_FFFC);
    tick(0, 0, 0, 1);
    check("wrap_zero_pc", id_pc, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rpc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 80));
      tick($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0);
    end
    check("misalign_sticky", {31'b0, fetch_misalign}, 32'h1);

`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched_end", perf_fetched, m_fetched);
    check("perf_bubbles_end", perf_bubbles, m_bubbles);
`endif

    // Mid-stream reset at pc = 0x18.
    tick(1, 32'h14, 0, 1);
    tick(0, 0, 0, 1);
    check("pre_reset_addr", {28'b0, imem_addr}, 32'h6);
    @(negedge clk);
    do_reset();
    boot_check("rerun");

`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched_final", perf_fetched, m_fetched);
    check("perf_bubbles_final", perf_bubbles, m_bubbles);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
